// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_pkg
// Brief    : Default 640x480@60 timing, colour-mode encodings and the shared
//            sync/active region decode used by both axis timers.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int C_H_PW   = 96;
    localparam int C_H_BP   = 48;
    localparam int C_H_DISP = 640;
    localparam int C_H_FP   = 16;
    localparam int C_H_TOT  = C_H_PW + C_H_BP + C_H_DISP + C_H_FP;

    localparam int C_V_PW   = 2;
    localparam int C_V_BP   = 29;
    localparam int C_V_DISP = 480;
    localparam int C_V_FP   = 10;
    localparam int C_V_TOT  = C_V_PW + C_V_BP + C_V_DISP + C_V_FP;

    localparam logic MODE_MONO   = 1'b0;
    localparam logic MODE_DIRECT = 1'b1;

    // Regions are half-open and start at count 0: [0,pw) sync, [pw+bp, pw+bp+disp) active.
    function automatic logic [1:0] region_flags(
        input int count,
        input int pw,
        input int bp,
        input int disp
    );
        logic w_sync;
        logic w_active;
        w_sync   = (count < pw);
        w_active = (count >= pw + bp) && (count < pw + bp + disp);
        return {w_sync, w_active};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_timer.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_timer
// Brief    : Enable-gated wrapping counter for one display axis, with sync and
//            active region flags and a wrap pulse for cascading.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_timer
    import vga_pkg::*;
#(
    parameter int TOTAL = C_H_TOT,
    parameter int PW    = C_H_PW,
    parameter int BP    = C_H_BP,
    parameter int DISP  = C_H_DISP,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_sync,
    output logic             o_active,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] r_count;
    logic [1:0]       w_flags;
    logic             w_at_last;

    assign w_at_last = (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

    // Combinational so the next axis advances on the same edge this one wraps.
    assign o_wrap   = i_en & w_at_last;
    assign w_flags  = region_flags(32'(r_count), PW, BP, DISP);
    assign o_sync   = w_flags[1];
    assign o_active = w_flags[0];
    assign o_count  = r_count;

endmodule
`default_nettype wire

// File: rtl/vga_sig_gen_param.sv
`default_nettype none
// ============================================================================
// Module   : vga_sig_gen_param
// Brief    : Parametrised VGA timing generator with a two-stage pixel pipeline
//            between the frame-buffer read port and the VGA pins.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sig_gen_param
    import vga_pkg::*;
#(
    parameter int   CLK_DIV     = 4,
    parameter int   H_PW        = C_H_PW,
    parameter int   H_BP        = C_H_BP,
    parameter int   H_DISP      = C_H_DISP,
    parameter int   H_FP        = C_H_FP,
    parameter int   V_PW        = C_V_PW,
    parameter int   V_BP        = C_V_BP,
    parameter int   V_DISP      = C_V_DISP,
    parameter int   V_FP        = C_V_FP,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   COORD_W     = 10,
    parameter int   SCALE_SHIFT = 2,
    parameter int   ADDR_X_W    = 8,
    parameter int   ADDR_Y_W    = 7
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         MODE,
    input  logic [15:0]                  CONFIG_COLOURS,
    input  logic [7:0]                   VGA_DATA,
    output logic                         PIX_EN,
    output logic [ADDR_Y_W+ADDR_X_W-1:0] VGA_ADDR,
    output logic [COORD_W-1:0]           ADDRH,
    output logic [COORD_W-1:0]           ADDRV,
    output logic                         VGA_HS,
    output logic                         VGA_VS,
    output logic                         DE,
    output logic [7:0]                   VGA_COLOUR,
    output logic                         FRAME_START
);

    localparam int c_H_TOT   = H_PW + H_BP + H_DISP + H_FP;
    localparam int c_V_TOT   = V_PW + V_BP + V_DISP + V_FP;
    localparam int c_MAX_TOT = (c_H_TOT > c_V_TOT) ? c_H_TOT : c_V_TOT;
    localparam int c_CNT_W   = (c_MAX_TOT > 1) ? $clog2(c_MAX_TOT) : 1;
    localparam int c_A_W     = ADDR_Y_W + ADDR_X_W;

    localparam logic [c_CNT_W-1:0] c_H_OFF = c_CNT_W'(H_PW + H_BP);
    localparam logic [c_CNT_W-1:0] c_V_OFF = c_CNT_W'(V_PW + V_BP);

    logic               w_pix_en;
    logic [c_CNT_W-1:0] w_hc;
    logic [c_CNT_W-1:0] w_vc;
    logic               w_hsync;
    logic               w_vsync;
    logic               w_hact;
    logic               w_vact;
    logic               w_act;
    logic               w_h_wrap;
    logic               w_v_wrap;

    logic [COORD_W-1:0] w_addrh_next;
    logic [COORD_W-1:0] w_addrv_next;
    logic [c_A_W-1:0]   w_vga_addr_next;
    logic [7:0]         w_mono_colour;
    logic [7:0]         w_colour_next;

    logic               r_hs1;
    logic               r_vs1;
    logic               r_de1;
    logic [COORD_W-1:0] r_addrh;
    logic [COORD_W-1:0] r_addrv;
    logic [c_A_W-1:0]   r_vga_addr;

    logic               r_hs;
    logic               r_vs;
    logic               r_de;
    logic [7:0]         r_colour;

    // ------------------------------------------------------------------------
    // Pixel-rate divider
    // ------------------------------------------------------------------------
    generate
        if (CLK_DIV > 1) begin : g_div
            localparam int                 c_DIV_W    = $clog2(CLK_DIV);
            localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

            logic [c_DIV_W-1:0] r_div;

            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    r_div <= '0;
                end else if (w_pix_en) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign w_pix_en = (r_div == c_DIV_LAST);
        end else begin : g_div_bypass
            assign w_pix_en = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Horizontal and vertical position counters
    // ------------------------------------------------------------------------
    vga_axis_timer #(
        .TOTAL (c_H_TOT),
        .PW    (H_PW),
        .BP    (H_BP),
        .DISP  (H_DISP),
        .CNT_W (c_CNT_W)
    ) u_h_timer (
        .clk      (CLK),
        .rst_n    (RESET),
        .i_en     (w_pix_en),
        .o_count  (w_hc),
        .o_sync   (w_hsync),
        .o_active (w_hact),
        .o_wrap   (w_h_wrap)
    );

    vga_axis_timer #(
        .TOTAL (c_V_TOT),
        .PW    (V_PW),
        .BP    (V_BP),
        .DISP  (V_DISP),
        .CNT_W (c_CNT_W)
    ) u_v_timer (
        .clk      (CLK),
        .rst_n    (RESET),
        .i_en     (w_h_wrap),
        .o_count  (w_vc),
        .o_sync   (w_vsync),
        .o_active (w_vact),
        .o_wrap   (w_v_wrap)
    );

    // ------------------------------------------------------------------------
    // Stage 1: coordinates, frame-buffer address and region flags
    // ------------------------------------------------------------------------
    assign w_act        = w_hact & w_vact;
    assign w_addrh_next = w_act ? COORD_W'(w_hc - c_H_OFF) : '0;
    assign w_addrv_next = w_act ? COORD_W'(w_vc - c_V_OFF) : '0;

    // Drop the scale bits so each frame-buffer cell covers 2^SCALE_SHIFT pixels per axis.
    assign w_vga_addr_next = {ADDR_Y_W'(w_addrv_next >> SCALE_SHIFT),
                              ADDR_X_W'(w_addrh_next >> SCALE_SHIFT)};

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_hs1      <= 1'b0;
            r_vs1      <= 1'b0;
            r_de1      <= 1'b0;
            r_addrh    <= '0;
            r_addrv    <= '0;
            r_vga_addr <= '0;
        end else if (w_pix_en) begin
            r_hs1      <= w_hsync;
            r_vs1      <= w_vsync;
            r_de1      <= w_act;
            r_addrh    <= w_addrh_next;
            r_addrv    <= w_addrv_next;
            r_vga_addr <= w_vga_addr_next;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: pin-level sync, data enable and colour
    // ------------------------------------------------------------------------
    assign w_mono_colour = VGA_DATA[0] ? CONFIG_COLOURS[15:8] : CONFIG_COLOURS[7:0];
    assign w_colour_next = !r_de1                ? 8'h00    :
                           (MODE == MODE_DIRECT) ? VGA_DATA : w_mono_colour;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_hs     <= ~HS_POL;
            r_vs     <= ~VS_POL;
            r_de     <= 1'b0;
            r_colour <= 8'h00;
        end else if (w_pix_en) begin
            r_hs     <= r_hs1 ? HS_POL : ~HS_POL;
            r_vs     <= r_vs1 ? VS_POL : ~VS_POL;
            r_de     <= r_de1;
            r_colour <= w_colour_next;
        end
    end

    assign PIX_EN      = w_pix_en;
    assign FRAME_START = w_v_wrap;
    assign VGA_ADDR    = r_vga_addr;
    assign ADDRH       = r_addrh;
    assign ADDRV       = r_addrv;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign DE          = r_de;
    assign VGA_COLOUR  = r_colour;

endmodule
`default_nettype wire

// File: tb/tb_vga_sig_gen_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sig_gen_param
// Brief    : Scoreboard bench for two small-timing instances (CLK_DIV=1 and a
//            divided, active-high-sync, scaled variant).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sig_gen_param;
    import vga_pkg::*;

    localparam int T_HPW = 2, T_HBP = 2, T_HDISP = 4, T_HFP = 2;
    localparam int T_VPW = 1, T_VBP = 1, T_VDISP = 3, T_VFP = 1;
    localparam int H_TOT = T_HPW + T_HBP + T_HDISP + T_HFP;
    localparam int V_TOT = T_VPW + T_VBP + T_VDISP + T_VFP;

    typedef struct { int div_n; bit pol; int shift; int xw; int yw; } cfg_t;
    typedef struct { bit hs; bit vs; bit de; int ah; int av; int addr; } entry_t;
    typedef struct { int div; int hc; int vc; } pos_t;
    typedef struct { bit pix; bit fs; bit hs; bit vs; bit de; int ah; int av; int addr; bit [7:0] col; } exp_t;

    cfg_t   cfg [2] = '{'{1, 1'b0, 0, 8, 7}, '{3, 1'b1, 1, 3, 2}};
    pos_t   pos [2];
    exp_t   ex  [2];
    entry_t qa[$];
    entry_t qb[$];
    entry_t zero_e;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] cfg_col = 16'hE003;
    int          sel = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int a_cyc    = 0;
    bit a_fs_seen = 1'b0;

    logic        a_pix, a_hs, a_vs, a_de, a_fs;
    logic [14:0] a_addr;
    logic [9:0]  a_addrh, a_addrv;
    logic [7:0]  a_col, a_data;

    logic        b_pix, b_hs, b_vs, b_de, b_fs;
    logic [4:0]  b_addr;
    logic [3:0]  b_addrh, b_addrv;
    logic [7:0]  b_col, b_data;

    always #5 clk = ~clk;

    function automatic bit [7:0] fmem(input int addr, input int s);
        bit [7:0] a8;
        a8 = addr[7:0];
        case (s)
            0:       return {7'd0, a8[0]};
            1:       return a8;
            default: return a8 ^ 8'hA5;
        endcase
    endfunction

    assign a_data = fmem(int'(a_addr), sel);
    assign b_data = fmem(int'(b_addr), sel);

    vga_sig_gen_param #(
        .CLK_DIV(1), .H_PW(T_HPW), .H_BP(T_HBP), .H_DISP(T_HDISP), .H_FP(T_HFP),
        .V_PW(T_VPW), .V_BP(T_VBP), .V_DISP(T_VDISP), .V_FP(T_VFP),
        .HS_POL(1'b0), .VS_POL(1'b0), .COORD_W(10), .SCALE_SHIFT(0),
        .ADDR_X_W(8), .ADDR_Y_W(7)
    ) u_dut_a (
        .CLK(clk), .RESET(rst_n), .MODE(mode), .CONFIG_COLOURS(cfg_col),
        .VGA_DATA(a_data), .PIX_EN(a_pix), .VGA_ADDR(a_addr), .ADDRH(a_addrh),
        .ADDRV(a_addrv), .VGA_HS(a_hs), .VGA_VS(a_vs), .DE(a_de),
        .VGA_COLOUR(a_col), .FRAME_START(a_fs)
    );

    vga_sig_gen_param #(
        .CLK_DIV(3), .H_PW(T_HPW), .H_BP(T_HBP), .H_DISP(T_HDISP), .H_FP(T_HFP),
        .V_PW(T_VPW), .V_BP(T_VBP), .V_DISP(T_VDISP), .V_FP(T_VFP),
        .HS_POL(1'b1), .VS_POL(1'b1), .COORD_W(4), .SCALE_SHIFT(1),
        .ADDR_X_W(3), .ADDR_Y_W(2)
    ) u_dut_b (
        .CLK(clk), .RESET(rst_n), .MODE(mode), .CONFIG_COLOURS(cfg_col),
        .VGA_DATA(b_data), .PIX_EN(b_pix), .VGA_ADDR(b_addr), .ADDRH(b_addrh),
        .ADDRV(b_addrv), .VGA_HS(b_hs), .VGA_VS(b_vs), .DE(b_de),
        .VGA_COLOUR(b_col), .FRAME_START(b_fs)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    endtask

    function automatic entry_t make_entry(input cfg_t c, input int hc, input int vc);
        entry_t e;
        bit     hact, vact;
        e.hs = (hc < T_HPW);
        e.vs = (vc < T_VPW);
        hact = (hc >= T_HPW + T_HBP) && (hc < T_HPW + T_HBP + T_HDISP);
        vact = (vc >= T_VPW + T_VBP) && (vc < T_VPW + T_VBP + T_VDISP);
        e.de = hact && vact;
        e.ah = e.de ? hc - (T_HPW + T_HBP) : 0;
        e.av = e.de ? vc - (T_VPW + T_VBP) : 0;
        e.addr = (((e.av >> c.shift) % (1 << c.yw)) << c.xw) + ((e.ah >> c.shift) % (1 << c.xw));
        return e;
    endfunction

    function automatic bit [7:0] colour(input entry_t e, input bit m, input bit [15:0] cc, input int s);
        bit [7:0] d;
        d = fmem(e.addr, s);
        if (!e.de) return 8'h00;
        if (m) return d;
        return d[0] ? cc[15:8] : cc[7:0];
    endfunction

    // Advance model k over the clock edge that just happened (inputs are stable across it).
    task automatic step(input int k);
        entry_t nxt, old;
        if (!rst_n) begin
            pos[k] = '{0, 0, 0};
            if (k == 0) begin qa.delete(); qa.push_back(zero_e); end
            else        begin qb.delete(); qb.push_back(zero_e); end
            ex[k].hs = !cfg[k].pol; ex[k].vs = !cfg[k].pol; ex[k].de = 1'b0;
            ex[k].col = 8'h00; ex[k].ah = 0; ex[k].av = 0; ex[k].addr = 0;
        end else if (pos[k].div == cfg[k].div_n - 1) begin
            nxt = make_entry(cfg[k], pos[k].hc, pos[k].vc);
            if (k == 0) begin old = qa.pop_front(); qa.push_back(nxt); end
            else        begin old = qb.pop_front(); qb.push_back(nxt); end
            ex[k].hs   = old.hs ? cfg[k].pol : !cfg[k].pol;
            ex[k].vs   = old.vs ? cfg[k].pol : !cfg[k].pol;
            ex[k].de   = old.de;
            ex[k].col  = colour(old, mode, cfg_col, sel);
            ex[k].ah   = nxt.ah;
            ex[k].av   = nxt.av;
            ex[k].addr = nxt.addr;
            pos[k].div = 0;
            if (pos[k].hc == H_TOT - 1) begin
                pos[k].hc = 0;
                pos[k].vc = (pos[k].vc == V_TOT - 1) ? 0 : pos[k].vc + 1;
            end else begin
                pos[k].hc++;
            end
        end else begin
            pos[k].div++;
        end
        ex[k].pix = (pos[k].div == cfg[k].div_n - 1);
        ex[k].fs  = ex[k].pix && (pos[k].hc == H_TOT - 1) && (pos[k].vc == V_TOT - 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            step(0);
            step(1);
            if (!rst_n) begin a_cyc = 0; a_fs_seen = 1'b0; end
            else a_cyc++;

            check("A.pix_en", a_pix, ex[0].pix);
            check("A.frame_start", a_fs, ex[0].fs);
            check("A.hs", a_hs, ex[0].hs);
            check("A.vs", a_vs, ex[0].vs);
            check("A.de", a_de, ex[0].de);
            check("A.colour", int'(a_col), int'(ex[0].col));
            check("A.addrh", int'(a_addrh), ex[0].ah);
            check("A.addrv", int'(a_addrv), ex[0].av);
            check("A.vga_addr", int'(a_addr), ex[0].addr);

            check("B.pix_en", b_pix, ex[1].pix);
            check("B.frame_start", b_fs, ex[1].fs);
            check("B.hs", b_hs, ex[1].hs);
            check("B.vs", b_vs, ex[1].vs);
            check("B.de", b_de, ex[1].de);
            check("B.colour", int'(b_col), int'(ex[1].col));
            check("B.addrh", int'(b_addrh), ex[1].ah);
            check("B.addrv", int'(b_addrv), ex[1].av);
            check("B.vga_addr", int'(b_addr), ex[1].addr);

            if (a_fs && !a_fs_seen) begin
                check("A.first_frame_start_cycle", a_cyc, 59);
                a_fs_seen = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Steady-state duty over 180 CLKs (three A frames, one B frame).
    task automatic window_counts();
        int ahs = 0, avs = 0, ade = 0, bhs = 0, bvs = 0, bde = 0;
        for (int i = 0; i < 180; i++) begin
            tick(1);
            if (!a_hs) ahs++;
            if (!a_vs) avs++;
            if (a_de)  ade++;
            if (b_hs)  bhs++;
            if (b_vs)  bvs++;
            if (b_de)  bde++;
        end
        check("A.hs_active_cycles", ahs, 36);
        check("A.vs_active_cycles", avs, 30);
        check("A.de_cycles", ade, 36);
        check("B.hs_active_cycles", bhs, 36);
        check("B.vs_active_cycles", bvs, 30);
        check("B.de_cycles", bde, 36);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; mode = MODE_MONO; cfg_col = 16'hE003; sel = 0;
        tick(3);
        rst_n = 1'b1;
        tick(130);
        window_counts();

        mode = MODE_DIRECT; sel = 1;
        tick(120);

        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1);
            if (pos[0].hc == 6 && pos[0].vc == 2) found = 1'b1;
        end
        check("reset_align", int'(found), 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;

        mode = MODE_MONO; cfg_col = 16'h5AC3; sel = 2;
        tick(200);
        window_counts();

        for (int i = 0; i < 150; i++) begin
            if (i % 7 == 0) begin
                mode    = 1'($urandom_range(0, 1));
                sel     = int'($urandom_range(0, 2));
                cfg_col = 16'($urandom);
            end
            tick(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
